// File: rtl/pe_pkg.sv
// pe_pkg: shared widths and helpers for the tile MAC processing element.
// Holds the saturation bounds and the tile-depth clamp.
package pe_pkg;

   localparam int DATA_W_DEFAULT = 8;
   localparam int ACC_W_DEFAULT  = 20;
   localparam int K_MAX_DEFAULT  = 16;

   function automatic longint sat_hi(input int acc_w, input bit sgn);
      if (sgn)
         return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
      return (64'sd1 <<< acc_w) - 64'sd1;
   endfunction

   function automatic longint sat_lo(input int acc_w, input bit sgn);
      if (sgn)
         return -(64'sd1 <<< (acc_w - 1));
      return 64'sd0;
   endfunction

   function automatic int clamp_k(input int k, input int k_max);
      if (k < 1)
         return 1;
      if (k > k_max)
         return k_max;
      return k;
   endfunction

endpackage

// File: rtl/pe_tile_cnt.sv
// pe_tile_cnt: tile term counter for the PE.
// Strobes first_term/last_term only on accepted (valid, not cleared) terms.
module pe_tile_cnt
   import pe_pkg::*;
#(
   parameter int K_MAX = K_MAX_DEFAULT
) (
   input  logic                         i_clk,
   input  logic                         i_arst,
   input  logic                         i_valid,
   input  logic                         i_clear,
   input  logic [$clog2(K_MAX+1)-1:0]   i_k,
   output logic                         first_term,
   output logic                         last_term
);

   localparam int CW = $clog2(K_MAX + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] k_eff;
   logic [CW:0]   nxt;
   logic          take;

   assign k_eff      = CW'(clamp_k(int'(i_k), K_MAX));
   assign take       = i_valid & ~i_clear;
   assign nxt        = {1'b0, cnt_q} + (CW+1)'(1);
   assign first_term = take & (cnt_q == '0);
   assign last_term  = take & (nxt == {1'b0, k_eff});

   always_ff @(posedge i_clk) begin
      if (i_arst)
         cnt_q <= '0;
      else if (i_clear || last_term)
         cnt_q <= '0;
      else if (i_valid)
         cnt_q <= nxt[CW-1:0];
   end

endmodule

// File: rtl/pe_tile_mac.sv
// pe_tile_mac: systolic PE, K-term tile MAC with east/south forwarding.
// Define PE_SAT_EN for clamping accumulation and the o_sat flag.
module pe_tile_mac
   import pe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int ACC_W  = ACC_W_DEFAULT,
   parameter int K_MAX  = K_MAX_DEFAULT,
   parameter int SIGNED = 0
) (
   input  logic                         i_clk,
   input  logic                         i_arst,
   input  logic                         i_clear,
   input  logic [$clog2(K_MAX+1)-1:0]   i_k,
   input  logic                         i_valid,
   input  logic [DATA_W-1:0]            i_a,
   input  logic [DATA_W-1:0]            i_b,
   output logic                         o_valid,
   output logic [DATA_W-1:0]            o_a,
   output logic [DATA_W-1:0]            o_b,
   output logic                         o_y_valid,
   output logic [ACC_W-1:0]             o_y,
   output logic                         o_sat
);

   localparam bit SGN = (SIGNED != 0);

   if (ACC_W < 2 * DATA_W) begin : g_bad_w
      $error("pe_tile_mac: ACC_W must be >= 2*DATA_W");
   end

   logic                  first;
   logic                  last;
   logic                  ea;
   logic                  eb;
   logic [2*DATA_W-1:0]   p2;
   logic [ACC_W-1:0]      prod;
   logic [ACC_W-1:0]      base;
   logic [ACC_W-1:0]      acc_q;
   logic [ACC_W-1:0]      acc_d;

   pe_tile_cnt #(
      .K_MAX(K_MAX)
   ) u_cnt (
      .i_clk      (i_clk),
      .i_arst     (i_arst),
      .i_valid    (i_valid),
      .i_clear    (i_clear),
      .i_k        (i_k),
      .first_term (first),
      .last_term  (last)
   );

   // Operands widened to 2*DATA_W so one multiplier serves both modes.
   assign ea = SGN & i_a[DATA_W-1];
   assign eb = SGN & i_b[DATA_W-1];
   assign p2 = {{DATA_W{ea}}, i_a} * {{DATA_W{eb}}, i_b};

   if (SGN) begin : g_sx
      assign prod = ACC_W'($signed(p2));
   end else begin : g_zx
      assign prod = ACC_W'(p2);
   end

   assign base = first ? '0 : acc_q;

`ifdef PE_SAT_EN
   localparam logic signed [ACC_W+1:0] HI = (ACC_W+2)'(sat_hi(ACC_W, SGN));
   localparam logic signed [ACC_W+1:0] LO = (ACC_W+2)'(sat_lo(ACC_W, SGN));

   logic signed [ACC_W+1:0] bw;
   logic signed [ACC_W+1:0] pw;
   logic signed [ACC_W+1:0] sw;
   logic                    hi_c;
   logic                    lo_c;
   logic                    sat_q;
   logic                    sat_y;
   logic                    sat_n;

   // Two guard bits hold any single step of either signedness.
   assign bw    = {{2{SGN & base[ACC_W-1]}}, base};
   assign pw    = {{2{SGN & prod[ACC_W-1]}}, prod};
   assign sw    = bw + pw;
   assign hi_c  = sw > HI;
   assign lo_c  = sw < LO;
   assign sat_n = sat_q | hi_c | lo_c;

   always_comb begin
      acc_d = sw[ACC_W-1:0];
      if (hi_c)
         acc_d = HI[ACC_W-1:0];
      else if (lo_c)
         acc_d = LO[ACC_W-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         sat_q <= 1'b0;
         sat_y <= 1'b0;
      end else begin
         sat_y <= last & sat_n;
         if (i_clear || last)
            sat_q <= 1'b0;
         else if (i_valid)
            sat_q <= sat_n;
      end
   end

   assign o_sat = sat_y;
`else
   assign acc_d = base + prod;
   assign o_sat = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         o_valid   <= 1'b0;
         o_a       <= '0;
         o_b       <= '0;
         o_y_valid <= 1'b0;
         o_y       <= '0;
         acc_q     <= '0;
      end else begin
         o_valid   <= i_valid;
         o_a       <= i_a;
         o_b       <= i_b;
         o_y_valid <= last;
         if (last) begin
            o_y   <= acc_d;
            acc_q <= '0;
         end else if (i_clear) begin
            acc_q <= '0;
         end else if (i_valid) begin
            acc_q <= acc_d;
         end
      end
   end

endmodule

// File: tb/tb_pe_tile_mac.sv
// tb_pe_tile_mac: three PE configurations driven by one stream and
// checked every cycle against a tile-level reference model.
module tb_pe_tile_mac;

   localparam int NDUT = 3;
   localparam int ACCW [NDUT] = '{20, 20, 16};
   localparam bit SGNS [NDUT] = '{1'b0, 1'b1, 1'b0};

   logic        clk = 1'b0;
   logic        arst = 1'b0;
   logic        clr = 1'b0;
   logic        vld = 1'b0;
   logic [4:0]  k = 5'd1;
   logic [7:0]  a = 8'd0;
   logic [7:0]  b = 8'd0;

   logic        vo [NDUT];
   logic [7:0]  ao [NDUT];
   logic [7:0]  bo [NDUT];
   logic        yv [NDUT];
   logic        so [NDUT];
   logic [19:0] y0;
   logic [19:0] y1;
   logic [15:0] y2;

   int checks = 0;
   int failures = 0;

   logic [15:0] q [$];
   logic [63:0] exp_y [NDUT];
   logic        exp_sat [NDUT];
   logic        exp_yv;
   logic        exp_v;
   logic [7:0]  exp_a;
   logic [7:0]  exp_b;

   always #5 clk = ~clk;

   pe_tile_mac u_dut (
      .i_clk(clk), .i_arst(arst), .i_clear(clr), .i_k(k),
      .i_valid(vld), .i_a(a), .i_b(b),
      .o_valid(vo[0]), .o_a(ao[0]), .o_b(bo[0]),
      .o_y_valid(yv[0]), .o_y(y0), .o_sat(so[0])
   );

   pe_tile_mac #(.SIGNED(1)) u_sdut (
      .i_clk(clk), .i_arst(arst), .i_clear(clr), .i_k(k),
      .i_valid(vld), .i_a(a), .i_b(b),
      .o_valid(vo[1]), .o_a(ao[1]), .o_b(bo[1]),
      .o_y_valid(yv[1]), .o_y(y1), .o_sat(so[1])
   );

   pe_tile_mac #(.ACC_W(16)) u_odut (
      .i_clk(clk), .i_arst(arst), .i_clear(clr), .i_k(k),
      .i_valid(vld), .i_a(a), .i_b(b),
      .o_valid(vo[2]), .o_a(ao[2]), .o_b(bo[2]),
      .o_y_valid(yv[2]), .o_y(y2), .o_sat(so[2])
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int keff(input logic [4:0] kv);
      if (kv == 0)
         return 1;
      if (kv > 16)
         return 16;
      return int'(kv);
   endfunction

   function automatic logic [63:0] y_of(input int d);
      case (d)
         0:       return 64'(y0);
         1:       return 64'(y1);
         default: return 64'(y2);
      endcase
   endfunction

   // Sum of the tile's products, clamped or wrapped at each step.
   function automatic void tile_result(input int acc_w, input bit sgn,
                                       output logic [63:0] y,
                                       output logic s);
      longint m;
      longint acc;
      longint p;
      m = 64'sd1 << acc_w;
      acc = 0;
      s = 1'b0;
      foreach (q[i]) begin
         if (sgn)
            p = longint'($signed(q[i][15:8])) * longint'($signed(q[i][7:0]));
         else
            p = longint'(q[i][15:8]) * longint'(q[i][7:0]);
         acc = acc + p;
`ifdef PE_SAT_EN
         if (sgn && acc > m / 2 - 1) begin
            acc = m / 2 - 1;
            s = 1'b1;
         end else if (sgn && acc < -(m / 2)) begin
            acc = -(m / 2);
            s = 1'b1;
         end else if (!sgn && acc > m - 1) begin
            acc = m - 1;
            s = 1'b1;
         end
`else
         acc = acc & (m - 1);
         if (sgn && acc >= m / 2)
            acc = acc - m;
`endif
      end
      y = 64'(acc & (m - 1));
   endfunction

   task automatic step(input logic v, input logic [7:0] ta,
                       input logic [7:0] tb, input logic c,
                       input logic r);
      vld = v;
      a = ta;
      b = tb;
      clr = c;
      arst = r;
      exp_yv = 1'b0;
      for (int d = 0; d < NDUT; d++)
         exp_sat[d] = 1'b0;
      if (r) begin
         q.delete();
         exp_v = 1'b0;
         exp_a = 8'd0;
         exp_b = 8'd0;
         for (int d = 0; d < NDUT; d++)
            exp_y[d] = 64'd0;
      end else begin
         exp_v = v;
         exp_a = ta;
         exp_b = tb;
         if (c) begin
            q.delete();
         end else if (v) begin
            q.push_back({ta, tb});
            if (q.size() == keff(k)) begin
               exp_yv = 1'b1;
               for (int d = 0; d < NDUT; d++)
                  tile_result(ACCW[d], SGNS[d], exp_y[d], exp_sat[d]);
               q.delete();
            end
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("o_valid[%0d]", d), 64'(vo[d]), 64'(exp_v));
         chk($sformatf("o_a[%0d]", d), 64'(ao[d]), 64'(exp_a));
         chk($sformatf("o_b[%0d]", d), 64'(bo[d]), 64'(exp_b));
         chk($sformatf("o_y_valid[%0d]", d), 64'(yv[d]), 64'(exp_yv));
         chk($sformatf("o_y[%0d]", d), y_of(d), exp_y[d]);
         chk($sformatf("o_sat[%0d]", d), 64'(so[d]), 64'(exp_sat[d]));
      end
   endtask

   task automatic term(input logic [7:0] ta, input logic [7:0] tb);
      step(1'b1, ta, tb, 1'b0, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
   endtask

   initial begin
      step(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
      idle();
      chk("idle_y", 64'(y0), 64'd0);

      k = 5'd4;
      repeat (4) term(8'd3, 8'd5);
      chk("k4_pulse", 64'(yv[0]), 64'd1);
      chk("k4_y", 64'(y0), 64'd60);
      idle();
      chk("k4_hold", 64'(y0), 64'd60);

      k = 5'd3;
      term(8'd2, 8'd2);
      idle();
      idle();
      term(8'd4, 8'd4);
      term(8'd1, 8'd255);
      chk("k3_bubble_y", 64'(y0), 64'd275);
      k = 5'd2;
      term(8'd10, 8'd10);
      term(8'd1, 8'd1);
      chk("k2_first_y", 64'(y0), 64'd101);
      term(8'd2, 8'd2);
      term(8'd3, 8'd3);
      chk("k2_second_y", 64'(y0), 64'd13);
      chk("k2_second_pulse", 64'(yv[0]), 64'd1);

      term(8'h80, 8'h80);
      term(8'hFF, 8'h05);
      chk("signed_y", 64'(y1), 64'd16379);
      term(8'h80, 8'h01);
      term(8'h00, 8'h00);
      chk("signed_neg_y", 64'(y1), 64'hFFF80);

      k = 5'd4;
      term(8'd7, 8'd7);
      term(8'd7, 8'd7);
      step(1'b1, 8'd9, 8'd9, 1'b1, 1'b0);
      chk("clear_no_pulse", 64'(yv[0]), 64'd0);
      repeat (4) term(8'd1, 8'd1);
      chk("clear_y", 64'(y0), 64'd4);

      k = 5'd2;
      term(8'd255, 8'd255);
      term(8'd255, 8'd255);
`ifdef PE_SAT_EN
      chk("ovf_y", 64'(y2), 64'd65535);
      chk("ovf_sat", 64'(so[2]), 64'd1);
`else
      chk("ovf_y", 64'(y2), 64'd64514);
      chk("ovf_sat", 64'(so[2]), 64'd0);
`endif
      term(8'd1, 8'd1);
      term(8'd1, 8'd1);
      chk("after_ovf_y", 64'(y2), 64'd2);
      chk("after_ovf_sat", 64'(so[2]), 64'd0);

      k = 5'd0;
      term(8'd6, 8'd7);
      chk("k0_as_1", 64'(y0), 64'd42);
      k = 5'd31;
      repeat (16) term(8'd1, 8'd2);
      chk("k31_as_16", 64'(y0), 64'd32);

      for (int n = 0; n < 400; n++) begin
         if (q.size() == 0 && $urandom_range(0, 4) == 0)
            k = 5'($urandom_range(0, 31));
         step($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom),
              $urandom_range(0, 19) == 0, 1'b0);
      end

      term(8'd9, 8'd9);
      step(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
      k = 5'd1;
      term(8'd2, 8'd3);
      chk("post_reset_y", 64'(y0), 64'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pe_tile_mac.md
Name: pe_tile_mac

Overview:
- Parametrised processing element for the 2D systolic array multiplier; successor to the fixed 8-bit free-running PE.
- Multiplies the operands entering the cell and accumulates the products over a programmable tile depth of K terms. When a tile completes, it emits a valid-qualified result and restarts the accumulator.
- Operands and valid are forwarded east/south through registers, so the array is a true one-cycle-per-hop systolic pipeline.
- Adds signed mode, abort/clear, and optional saturation.

Parameters:
- DATA_W, 8: operand width (i_a, i_b, o_a, o_b).
- ACC_W, 20: accumulator/result width. Must be >= 2*DATA_W; elaboration-time assertion.
- K_MAX, 16: maximum tile depth. Counter width is $clog2(K_MAX+1).
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands, product sign-extended to ACC_W.

Ports:
- i_clk  in  1  clock.
- i_arst  in  1  reset; synchronous, active-high (sampled on posedge i_clk only).
- i_clear  in  1  synchronous tile abort.
- i_k  in  $clog2(K_MAX+1)  tile depth. Static while a tile is in progress; 0 treated as 1; values > K_MAX treated as K_MAX.
- i_valid  in  1  i_a/i_b carry a term this cycle.
- i_a  in  DATA_W  west operand.
- i_b  in  DATA_W  north operand.
- o_valid  out  1  registered i_valid (east/south).
- o_a  out  DATA_W  registered i_a (east).
- o_b  out  DATA_W  registered i_b (south).
- o_y_valid  out  1  one-cycle pulse: o_y holds a new tile result.
- o_y  out  ACC_W  last completed tile result.
- o_sat  out  1  result flag qualified by o_y_valid; see Optional Feature.

Behaviour:
- Reset (i_arst=1 at posedge): all outputs, acc_q and cnt_q go to 0. Reset overrides i_clear and i_valid.
- Forwarding: o_a, o_b and o_valid equal i_a, i_b and i_valid delayed exactly 1 cycle.
  - o_a and o_b update every cycle regardless of i_valid.
  - Forwarding is unaffected by i_clear.
- Product: prod = i_a*i_b at 2*DATA_W, extended to ACC_W (zero-extended if SIGNED=0, sign-extended if SIGNED=1).
- Accumulate on a cycle with i_valid=1 and i_clear=0:
  - If cnt_q==0: acc_d = prod. Otherwise acc_d = acc_q + prod.
  - If cnt_q+1 == k_eff: o_y <= acc_d, o_y_valid <= 1 on the next cycle, cnt_q <= 0, acc_q <= 0.
  - Otherwise: cnt_q <= cnt_q+1, acc_q <= acc_d.
- Cycles with i_valid=0: acc_q and cnt_q hold. Bubbles inside a tile are legal.
- Latency: o_y_valid asserts 1 cycle after the cycle carrying the k-th valid term.
  - Back-to-back tiles with no gap are supported.
  - k=1 gives one result per valid term.
- o_y holds its value between pulses; o_y_valid is otherwise 0.
- i_clear=1: cnt_q <= 0 and acc_q <= 0. Any i_valid term in the same cycle is discarded and no result is emitted that cycle.
  - Because i_clear discards the term, it also suppresses a completion that would have occurred that cycle.
  - o_y keeps its previous value.
- Arithmetic without saturation wraps modulo 2^ACC_W.

Optional Feature:
- Macro: PE_SAT_EN.
- Defined:
  - Every accumulate step (including the first term) clamps to the ACC_W range: unsigned [0, 2^ACC_W-1]; signed [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - A sticky per-tile flag records any clamp; o_sat presents it alongside o_y_valid.
  - The flag clears at tile completion, i_clear and reset.
- Undefined: wrap-around arithmetic; o_sat tied 0; no clamp logic synthesised.

Decomposition:
- Package pe_pkg:
  - Default widths (DATA_W_DEFAULT=8, ACC_W_DEFAULT=20, K_MAX_DEFAULT=16).
  - Function for saturation bounds given ACC_W/SIGNED.
  - Function clamping i_k to a legal k_eff.
- Sub-module pe_tile_cnt: holds cnt_q and k_eff, and outputs first_term and last_term strobes. Inputs: i_valid, i_clear, i_k.
- The MAC datapath and forwarding registers stay in pe_tile_mac.

Test Plan:
- Reset: drive i_arst=1 with i_valid=1, a=b=0xFF → all outputs 0 on the following cycle. Release → cell idle, o_y=0.
- Unsigned, k=4, four consecutive terms 3*5 → o_y=60 with o_y_valid high for exactly 1 cycle, 1 cycle after the 4th term. o_a/o_b trail the inputs by 1 cycle.
- k=3 with bubbles: terms 2*2, two idle cycles, 4*4, 1*255 → o_y=275. Then immediately k=2 terms 10*10, 1*1 followed by 2*2, 3*3 back-to-back → pulses with o_y=101 then 13, 2 cycles apart.
- SIGNED=1, k=2: (-128)*(-128), then (-1)*5 → o_y=16379. A second tile 0x80*0x01, 0*0 → o_y=-128 sign-extended (0xFFF80 at ACC_W=20).
- i_clear: k=4, two terms 7*7, then i_clear together with a valid term 9*9, then four terms 1*1 → single pulse with o_y=4; no pulse for the aborted tile.
- Overflow, ACC_W=16, unsigned, k=2, 255*255 twice:
  - Without PE_SAT_EN → o_y=64514, o_sat=0.
  - With PE_SAT_EN → o_y=65535, o_sat=1; the next tile 1*1, 1*1 → o_y=2, o_sat=0.
